// File: rtl/data_memory_if.sv
// Load/store port between the core and the byte-addressed data memory.
// Lane i of each word carries the byte at mem_addr+i (little-endian).
interface data_memory_if;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic            mem_write_en;
    logic            halted;
    logic [0:3][7:0] mem_data_out;
    logic            mem_rd_valid;

    modport master (
        output mem_addr, mem_data_in, mem_write_en, halted,
        input  mem_data_out, mem_rd_valid
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_write_en, halted,
        output mem_data_out, mem_rd_valid
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed data memory: four little-endian lanes, wrap-around addressing,
// single-cycle stores gated by halt, read-before-write pipelined read path.
module data_memory #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_b,
    data_memory_if.slave bus
);

    typedef logic [0:3][7:0] word_t;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_memory: READ_LATENCY must be in 1..4");
    end

    if (ADDR_WIDTH < 32) begin : g_alias
        // Upper address bits alias onto the decoded range by design.
        logic unused_upper_addr;
        assign unused_upper_addr = ^bus.mem_addr[31:ADDR_WIDTH];
    end

    logic [7:0]            mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] lane_addr [4];
    word_t                 rd_word;
    logic                  store_ok;
    word_t                 stage_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] stage_valid;

    // Each lane wraps independently modulo the capacity.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = bus.mem_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
            rd_word[i]   = mem[lane_addr[i]];
        end
    end

    assign store_ok = rst_b & bus.mem_write_en & ~bus.halted;

    // NOTE: the storage array is deliberately left out of reset so its contents
    // survive a reset pulse and it can map onto plain RAM; non-blocking writes
    // here are what make a same-edge read in the pipeline see the old bytes.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int i = 0; i < 4; i++) begin
                mem[lane_addr[i]] <= bus.mem_data_in[i];
            end
        end
    end

    // Reset flushes in-flight reads so the first valid word after release
    // always belongs to an address presented after release.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_data[i] <= '0;
            end
            stage_valid <= '0;
        end else begin
            stage_data[0]  <= rd_word;
            stage_valid[0] <= 1'b1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_data[i]  <= stage_data[i-1];
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    assign bus.mem_data_out = stage_data[READ_LATENCY-1];
    assign bus.mem_rd_valid = stage_valid[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a latency-1 instance for the store/read
// features and a latency-3 instance for pipelining and mid-flight reset.
module tb_data_memory;

    typedef logic [0:3][7:0] word_t;

    logic clk;
    logic rst_b1;
    logic rst_b3;

    data_memory_if bus1 ();
    data_memory_if bus3 ();

    data_memory #(.ADDR_WIDTH(16), .READ_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_b (rst_b1),
        .bus   (bus1.slave)
    );

    data_memory #(.ADDR_WIDTH(16), .READ_LATENCY(3)) u_dut3 (
        .clk   (clk),
        .rst_b (rst_b3),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference contents of each instance; only bytes ever stored are known.
    logic [7:0] model1 [int];
    logic [7:0] model3 [int];

    word_t exp1_q[$], mask1_q[$];
    string name1_q[$];
    word_t exp3_q[$], mask3_q[$];
    string name3_q[$];

    function automatic void lookup(input bit which, input logic [31:0] addr,
                                   output word_t e, output word_t m);
        logic [15:0] a;
        e = '0;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            a = addr[15:0] + 16'(i);
            if (!which && model1.exists(int'(a))) begin
                e[i] = model1[int'(a)];
                m[i] = 8'hFF;
            end else if (which && model3.exists(int'(a))) begin
                e[i] = model3[int'(a)];
                m[i] = 8'hFF;
            end
        end
    endfunction

    function automatic void store_model(input bit which, input logic [31:0] addr,
                                        input word_t data);
        logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a = addr[15:0] + 16'(i);
            if (!which) model1[int'(a)] = data[i];
            else        model3[int'(a)] = data[i];
        end
    endfunction

    // One cycle on the latency-1 instance; starts and ends on a falling edge.
    task automatic step1(input logic [31:0] addr, input word_t data, input bit we,
                         input bit hlt, input string name);
        word_t e, m, got;
        string nm;
        bus1.mem_addr     = addr;
        bus1.mem_data_in  = data;
        bus1.mem_write_en = we;
        bus1.halted       = hlt;
        lookup(1'b0, addr, e, m);
        exp1_q.push_back(e);
        mask1_q.push_back(m);
        name1_q.push_back(name);
        if (we && !hlt) store_model(1'b0, addr, data);
        @(posedge clk);
        #1;
        e  = exp1_q.pop_front();
        m  = mask1_q.pop_front();
        nm = name1_q.pop_front();
        n_cmp++;
        if (bus1.mem_rd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_valid: got %b expected 1", nm, bus1.mem_rd_valid);
        end
        if (m != '0) begin
            got = bus1.mem_data_out & m;
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (mask %h)", nm, got, e, m);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive3(input logic [31:0] addr, input word_t data, input bit we,
                          input string name);
        word_t e, m;
        bus3.mem_addr     = addr;
        bus3.mem_data_in  = data;
        bus3.mem_write_en = we;
        bus3.halted       = 1'b0;
        lookup(1'b1, addr, e, m);
        exp3_q.push_back(e);
        mask3_q.push_back(m);
        name3_q.push_back(name);
        if (we) store_model(1'b1, addr, data);
    endtask

    task automatic sample3(input bit exp_valid, input string tag);
        word_t e, m, got;
        string nm;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus3.mem_rd_valid !== exp_valid) begin
            n_bad++;
            $display("FAIL %s_valid: got %b expected %b", tag, bus3.mem_rd_valid, exp_valid);
        end
        if (!exp_valid) begin
            n_cmp++;
            if (bus3.mem_data_out !== 32'h0) begin
                n_bad++;
                $display("FAIL %s_zero: got %h expected 00000000", tag, bus3.mem_data_out);
            end
        end else if (exp3_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            e  = exp3_q.pop_front();
            m  = mask3_q.pop_front();
            nm = name3_q.pop_front();
            if (m != '0) begin
                got = bus3.mem_data_out & m;
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (mask %h)", nm, got, e, m);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input word_t out, input logic valid);
        n_cmp++;
        if (out !== 32'h0) begin
            n_bad++;
            $display("FAIL %s_data: got %h expected 00000000", tag, out);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_valid: got %b expected 0", tag, valid);
        end
    endtask

    task automatic test_reset();
        #2;
        rst_b1 = 1'b0;
        rst_b3 = 1'b0;
        #1;
        check_idle("reset1", bus1.mem_data_out, bus1.mem_rd_valid);
        check_idle("reset3", bus3.mem_data_out, bus3.mem_rd_valid);
        @(negedge clk);
        rst_b1 = 1'b1;
        step1(32'h0000_0000, 32'h0, 1'b0, 1'b0, "first_valid");
    endtask

    task automatic test_store_read();
        step1(32'h0000_0104, 32'h5566_7788, 1'b1, 1'b0, "preload_104");
        step1(32'h0000_0100, 32'h1122_3344, 1'b1, 1'b0, "store_100");
        step1(32'h0000_0100, 32'h0, 1'b0, 1'b0, "read_100");
        step1(32'h0000_0102, 32'h0, 1'b0, 1'b0, "read_102_unaligned");
    endtask

    task automatic test_read_before_write();
        step1(32'h0000_0200, 32'h0102_0304, 1'b1, 1'b0, "preload_200");
        step1(32'h0000_0200, 32'hAABB_CCDD, 1'b1, 1'b0, "rbw_old_200");
        step1(32'h0000_0200, 32'h0, 1'b0, 1'b0, "rbw_new_200");
    endtask

    task automatic test_wrap();
        step1(32'h0000_FFFE, 32'h5A5B_5C5D, 1'b1, 1'b0, "store_fffe");
        step1(32'h0000_0000, 32'h0, 1'b0, 1'b0, "read_0000_wrap");
        step1(32'h0000_FFFE, 32'h0, 1'b0, 1'b0, "read_fffe");
        step1(32'h0000_FFFF, 32'h0, 1'b0, 1'b0, "read_ffff");
        step1(32'h0001_FFFE, 32'hA1A2_A3A4, 1'b1, 1'b0, "store_alias_1fffe");
        step1(32'h0000_FFFE, 32'h0, 1'b0, 1'b0, "read_alias_fffe");
        step1(32'hABCD_0000, 32'h0, 1'b0, 1'b0, "read_alias_abcd0000");
    endtask

    task automatic test_halted();
        step1(32'h0000_0300, 32'h0102_0304, 1'b1, 1'b0, "preload_300");
        step1(32'h0000_0300, 32'hEEEE_EEEE, 1'b1, 1'b1, "halted_store_300");
        step1(32'h0000_0300, 32'h0, 1'b0, 1'b0, "halted_read_300");
    endtask

    task automatic test_reset_drop();
        step1(32'h0000_0400, 32'hC1C2_C3C4, 1'b1, 1'b0, "preload_400");
        rst_b1            = 1'b0;
        bus1.mem_addr     = 32'h0000_0400;
        bus1.mem_data_in  = 32'hFFFF_FFFF;
        bus1.mem_write_en = 1'b1;
        bus1.halted       = 1'b0;
        @(posedge clk);
        #1;
        check_idle("reset_store_edge", bus1.mem_data_out, bus1.mem_rd_valid);
        @(negedge clk);
        rst_b1 = 1'b1;
        step1(32'h0000_0400, 32'h0, 1'b0, 1'b0, "reset_store_dropped");
    endtask

    task automatic test_back_to_back();
        word_t w;
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            step1(32'h0000_0500 + 32'(8 * i), w, 1'b1, 1'b0, "b2b_store");
        end
        for (int i = 0; i < 6; i++) begin
            step1(32'h0000_0500 + 32'(8 * i), 32'h0, 1'b0, 1'b0, "b2b_read");
        end
        step1(32'h0000_0503, 32'h0, 1'b0, 1'b0, "b2b_read_503");
    endtask

    task automatic test_latency3();
        rst_b3 = 1'b1;
        drive3(32'h10, 32'hD0D1_D2D3, 1'b1, "l3_st10");   sample3(1'b0, "l3_e1");
        drive3(32'h14, 32'hE0E1_E2E3, 1'b1, "l3_st14");   sample3(1'b0, "l3_e2");
        drive3(32'h18, 32'hF0F1_F2F3, 1'b1, "l3_st18");   sample3(1'b1, "l3_e3");
        drive3(32'h10, 32'h0, 1'b0, "l3_rd10_pre");       sample3(1'b1, "l3_e4");
        drive3(32'h14, 32'h0, 1'b0, "l3_rd14_pre");       sample3(1'b1, "l3_e5");
        rst_b3 = 1'b0;
        #1;
        check_idle("l3_midreset", bus3.mem_data_out, bus3.mem_rd_valid);
        exp3_q.delete();
        mask3_q.delete();
        name3_q.delete();
        #1;
        rst_b3 = 1'b1;
        drive3(32'h18, 32'h0, 1'b0, "l3_rd18_post");      sample3(1'b0, "l3_p1");
        drive3(32'h10, 32'h0, 1'b0, "l3_rd10_post");      sample3(1'b0, "l3_p2");
        drive3(32'h14, 32'h0, 1'b0, "l3_rd14_post");      sample3(1'b1, "l3_p3");
        drive3(32'h12, 32'h0, 1'b0, "l3_rd12_post");      sample3(1'b1, "l3_p4");
        drive3(32'h10, 32'h0, 1'b0, "l3_drain_a");        sample3(1'b1, "l3_p5");
        drive3(32'h10, 32'h0, 1'b0, "l3_drain_b");        sample3(1'b1, "l3_p6");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b1            = 1'b1;
        rst_b3            = 1'b1;
        bus1.mem_addr     = '0;
        bus1.mem_data_in  = '0;
        bus1.mem_write_en = 1'b0;
        bus1.halted       = 1'b0;
        bus3.mem_addr     = '0;
        bus3.mem_data_in  = '0;
        bus3.mem_write_en = 1'b0;
        bus3.halted       = 1'b0;
        test_reset();
        test_store_read();
        test_read_before_write();
        test_wrap();
        test_halted();
        test_reset_drop();
        test_back_to_back();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressed data memory that services the core's load/store port: `mem_addr`, `mem_data_in`, `mem_write_en` in; `mem_data_out` back.
- Four byte lanes per access, little-endian.
- Pipelined read path with configurable latency; single-cycle synchronous writes.
- Writes are blocked once the core reports `halted`.

Parameters:
- ADDR_WIDTH, 16, number of address bits decoded; capacity is 2^ADDR_WIDTH bytes.
- READ_LATENCY, 1, clock edges from address presentation to data on `mem_data_out`. Legal range 1..4; anything else is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- mem_addr  input  32  byte address of lane 0; bits above ADDR_WIDTH-1 ignored (aliasing).
- mem_data_in  input  8 x [0:3]  write bytes; lane i targets address mem_addr+i.
- mem_write_en  input  1  store strobe, sampled on rising edge.
- halted  input  1  core halt flag; while high, stores are suppressed.
- mem_data_out  output  8 x [0:3]  read bytes; lane i = byte at address mem_addr+i, as sampled READ_LATENCY edges earlier.
- mem_rd_valid  output  1  high once the read pipeline holds data sampled after reset.

Behaviour:
- **Reset (rst_b=0, immediate, asynchronous):**
  - mem_data_out lanes all 8'h00.
  - All read-pipeline stages cleared to 0, with their valid bits cleared.
  - mem_rd_valid=0.
  - Storage array contents are NOT cleared; they are retained across reset.
  - A store whose edge coincides with rst_b low is dropped.
- **Lane addressing:**
  - Effective byte address for lane i is (mem_addr[ADDR_WIDTH-1:0] + i) mod 2^ADDR_WIDTH.
  - Unaligned accesses are legal.
  - An access starting at the last 1..3 bytes wraps to byte 0.
- **Store:**
  - On a rising edge with rst_b=1, mem_write_en=1 and halted=0, all four lanes are written.
  - No byte masking.
  - Store with halted=1 leaves the array unchanged; the read path is unaffected.
- **Read path:**
  - Reads are unconditional every cycle.
  - Stage 0 is captured at edge N from the array contents before that edge's store (read-before-write).
  - The captured value is shifted through READ_LATENCY-1 further register stages.
  - mem_data_out = final stage, so data for the address presented in cycle N appears after edge N+READ_LATENCY-1.
  - With READ_LATENCY=1: registered output one edge after the address.
  - Same-cycle store and read to overlapping bytes: read returns old bytes. The new bytes are visible to an address presented in any later cycle.
- **Valid tracking:**
  - A shift register of READ_LATENCY bits.
  - Shifts in 1 each edge out of reset.
  - mem_rd_valid = last bit; it rises after exactly READ_LATENCY edges following reset release and then stays high until the next reset.
- **Reset mid-operation:**
  - In-flight read stages are discarded.
  - The first valid output after release reflects an address presented after release.
- **Address width:** full 32-bit mem_addr accepted; upper bits silently ignored. No error flag.

Test Plan:
- Reset with READ_LATENCY=1 → mem_data_out={00,00,00,00}, mem_rd_valid=0; after first edge with rst_b=1, mem_rd_valid=1.
- Store addr 0x100, data {11,22,33,44}, we=1; next cycle read 0x100 → after one edge mem_data_out={11,22,33,44}; read 0x102 → {33,44,xx_prev,xx_prev} with lanes 2–3 equal to the preloaded bytes at 0x104/0x105.
- Same-cycle store {AA,BB,CC,DD} and read at 0x200 (previously {01,02,03,04}) → output {01,02,03,04}; read 0x200 next cycle → {AA,BB,CC,DD}.
- ADDR_WIDTH=16, store at 0xFFFE data {5A,5B,5C,5D} → bytes 0xFFFE=5A, 0xFFFF=5B, 0x0000=5C, 0x0001=5D; read 0x0000 → {5C,5D,...}; store at 0x0001FFFE aliases identically.
- halted=1, store {EE,EE,EE,EE} at 0x300 (holding {01,02,03,04}) → read 0x300 returns {01,02,03,04}.
- READ_LATENCY=3, addresses 0x10,0x14,0x18 on consecutive cycles; rst_b pulsed low after second edge → outputs zero immediately, mem_rd_valid=0; after release valid rises on third edge with data of the address presented at the first post-reset edge.
